// File: rtl/divisor_nbit_if.sv
// Request/result bundle for the iterative divider.
//
// Handshake: the master raises start with A, B and signed_mode valid; the
// request is taken on a rising clk edge where busy is low and ignored
// otherwise. done pulses for one cycle with Q, R, div_zero and ovf valid.
// These result signals hold until the next done.
interface divisor_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             done;
    logic             busy;
    logic             div_zero;
    logic             ovf;

    modport master (
        output start, signed_mode, A, B,
        input  Q, R, done, busy, div_zero, ovf
    );

    modport slave (
        input  start, signed_mode, A, B,
        output Q, R, done, busy, div_zero, ovf
    );
endinterface

// File: rtl/divisor_nbit.sv
// Iterative restoring divider, one quotient bit per clock.
// Operands are converted to magnitudes on acceptance. WIDTH shift/subtract
// steps follow, MSB first. One final cycle applies sign correction and
// publishes the result. A zero divisor bypasses the iteration entirely.
module divisor_nbit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    divisor_nbit_if.slave        bus,
    output logic [1:0]           dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Remaining iteration count; loaded with WIDTH and counted down to zero.
    logic [CW-1:0]    cnt;
    // Raw dividend, kept for the divide-by-zero result.
    logic [WIDTH-1:0] a_raw;
    // Divisor magnitude.
    logic [WIDTH-1:0] b_mag;
    // Partial remainder; it always stays below b_mag, so WIDTH bits suffice.
    logic [WIDTH-1:0] rem;
    // Dividend magnitude shifting out at the top while quotient bits shift in.
    logic [WIDTH-1:0] quo;
    logic             neg_q;
    logic             neg_r;
    logic             ovf_pend;
    // Divide-by-zero accepted; the result is published on the next edge.
    logic             dz_pend;

    logic             busy_int;
    logic             accept;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;
    logic             a_is_min;
    logic             b_is_neg_one;

    // Returns the magnitude of v. The value is treated as two's complement only when sm is set.
    // The most-negative value maps to 2**(WIDTH-1). That value still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
        return (sm && v[WIDTH-1]) ? -v : v;
    endfunction

    assign busy_int     = (state != IDLE) || dz_pend;
    assign accept       = bus.start && !busy_int;
    assign bus.busy     = busy_int;
    assign dbg_state    = state;

    assign a_is_min     = (bus.A == {1'b1, {(WIDTH-1){1'b0}}});
    assign b_is_neg_one = (bus.B == {WIDTH{1'b1}});

    // One restoring step: bring in the next dividend bit, then subtract if the divisor fits.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign fits    = (rem_sh >= {1'b0, b_mag});
    assign rem_sub = rem_sh[WIDTH-1:0] - b_mag;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A zero divisor never leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && (bus.B != '0)) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nxt = ADJ;
                end
            end
            ADJ: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and the iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_raw    <= '0;
            b_mag    <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
            dz_pend  <= 1'b0;
        end else begin
            dz_pend <= 1'b0;
            if (accept) begin
                a_raw    <= bus.A;
                b_mag    <= mag(bus.B, bus.signed_mode);
                quo      <= mag(bus.A, bus.signed_mode);
                rem      <= '0;
                cnt      <= CW'(WIDTH);
                neg_q    <= bus.signed_mode && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                neg_r    <= bus.signed_mode && bus.A[WIDTH-1];
                ovf_pend <= bus.signed_mode && a_is_min && b_is_neg_one;
                dz_pend  <= (bus.B == '0);
            end else if (state == CALC) begin
                rem <= fits ? rem_sub : rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], fits};
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Result registers. They change only on the edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Q        <= '0;
            bus.R        <= '0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.ovf      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (dz_pend) begin
                bus.Q        <= '1;
                bus.R        <= a_raw;
                bus.done     <= 1'b1;
                bus.div_zero <= 1'b1;
                bus.ovf      <= 1'b0;
            end else if (state == ADJ) begin
                // The MIN / -1 case needs no special handling here: its magnitude quotient
                // 2**(WIDTH-1) is not negated, so its bit pattern already equals MIN.
                bus.Q        <= neg_q ? -quo : quo;
                bus.R        <= neg_r ? -rem : rem;
                bus.done     <= 1'b1;
                bus.div_zero <= 1'b0;
                bus.ovf      <= ovf_pend;
            end
        end
    end
endmodule

// File: tb/tb_divisor_nbit.sv
// Bench for divisor_nbit (WIDTH = 8): table vectors, random operations against
// an arithmetic model, and hand-written multi-cycle sequences.
module tb_divisor_nbit;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    divisor_nbit_if #(.WIDTH(W)) bus ();

    divisor_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           lat;
        logic         busy1;
        logic         busy_done;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic model: integer division and remainder on the operand values.
    // Int division truncates toward zero, and the remainder takes the dividend's sign.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        vec_t m;
        int   sa;
        int   sb;
        int   qi;
        int   ri;
        m.a = a; m.b = b; m.sm = sm;
        if (b == 0) begin
            m.q = '1; m.r = a; m.dz = 1'b1; m.ovf = 1'b0; m.lat = 2;
            return m;
        end
        sa = (sm && a[W-1]) ? int'(a) - (1 << W) : int'(a);
        sb = (sm && b[W-1]) ? int'(b) - (1 << W) : int'(b);
        qi = sa / sb;
        ri = sa % sb;
        m.q   = qi[W-1:0];
        m.r   = ri[W-1:0];
        m.dz  = 1'b0;
        m.ovf = sm && (sa == -(1 << (W - 1))) && (sb == -1);
        m.lat = W + 2;
        return m;
    endfunction

    // Drives one request; the accepting edge counts as edge 1.
    // The operands are scrambled after acceptance, so an unlatched input would show up in the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, output obs_t o);
        o.lat = -1; o.busy1 = 1'b0; o.busy_done = 1'b1;
        o.q = '0; o.r = '0; o.dz = 1'b0; o.ovf = 1'b0;
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.signed_mode = sm;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 1) begin
                bus.start = 1'b0;
                bus.A = W'($urandom);
                bus.B = W'($urandom);
                bus.signed_mode = ~sm;
                o.busy1 = bus.busy;
            end
            if (bus.done) begin
                o.lat = e; o.q = bus.Q; o.r = bus.R; o.dz = bus.div_zero;
                o.ovf = bus.ovf; o.busy_done = bus.busy;
                break;
            end
        end
    endtask

    task automatic op_and_check(input string tag, input vec_t v);
        obs_t o;
        run_op(v.a, v.b, v.sm, o);
        check({tag, ".lat"}, o.lat, v.lat);
        check({tag, ".Q"}, o.q, v.q);
        check({tag, ".R"}, o.r, v.r);
        check({tag, ".div_zero"}, o.dz, v.dz);
        check({tag, ".ovf"}, o.ovf, v.ovf);
        check({tag, ".busy_after_accept"}, o.busy1, 1'b1);
        check({tag, ".busy_with_done"}, o.busy_done, 1'b0);
        tick();
        check({tag, ".done_one_cycle"}, bus.done, 1'b0);
    endtask

    vec_t vecs[12];
    vec_t mv;
    int   done_edges[$];
    logic [W-1:0] q1, r1, q2, r2;
    int   dones_in_reset;

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 10};
        vecs[1]  = '{8'd123, 8'd3,   1'b0, 8'd41,  8'd0,   1'b0, 1'b0, 10};
        vecs[2]  = '{8'd255, 8'd7,   1'b0, 8'd36,  8'd3,   1'b0, 1'b0, 10};
        vecs[3]  = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0, 10};
        vecs[4]  = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 1'b0, 10};
        vecs[5]  = '{8'h5A,  8'h00,  1'b0, 8'hFF,  8'h5A,  1'b1, 1'b0, 2};
        vecs[6]  = '{8'd10,  8'd3,   1'b0, 8'd3,   8'd1,   1'b0, 1'b0, 10};
        vecs[7]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1, 10};
        vecs[8]  = '{8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,  1'b0, 1'b0, 10};
        vecs[9]  = '{8'hF9,  8'hFE,  1'b1, 8'h03,  8'hFF,  1'b0, 1'b0, 10};
        vecs[10] = '{8'hC3,  8'h00,  1'b1, 8'hFF,  8'hC3,  1'b1, 1'b0, 2};
        vecs[11] = '{8'h80,  8'h01,  1'b1, 8'h80,  8'h00,  1'b0, 1'b0, 10};

        // Reset.
        rst_n = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.signed_mode = 1'b0;
        #3;
        check("reset.Q", bus.Q, '0);
        check("reset.R", bus.R, '0);
        check("reset.done", bus.done, 1'b0);
        check("reset.busy", bus.busy, 1'b0);
        check("reset.div_zero", bus.div_zero, 1'b0);
        check("reset.ovf", bus.ovf, 1'b0);
        check("reset.state", dbg_state, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Table vectors; the zero-divisor entry at index 5 is followed by a normal one that must clear div_zero.
        for (int i = 0; i < 12; i++) begin
            op_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Random operations against the model; zero divisors and MIN / -1 are injected occasionally.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         sm;
            a  = W'($urandom);
            b  = W'($urandom);
            sm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 9) == 0) begin
                a = {1'b1, {(W-1){1'b0}}}; b = '1; sm = 1'b1;
            end
            mv = model(a, b, sm);
            op_and_check($sformatf("rnd%0d", i), mv);
        end

        // A start while busy is ignored; a start in the done cycle is taken.
        done_edges.delete();
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        bus.start = 1'b1; bus.A = 8'd100; bus.B = 8'd9; bus.signed_mode = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e == 1 || e == 4 || e == 11) bus.start = 1'b0;
            if (e == 3) begin
                bus.start = 1'b1; bus.A = 8'd50; bus.B = 8'd5;
            end
            if (bus.done) begin
                done_edges.push_back(e);
                if (e == 10) begin
                    q1 = bus.Q; r1 = bus.R;
                    bus.start = 1'b1; bus.A = 8'd50; bus.B = 8'd5;
                end else if (e == 20) begin
                    q2 = bus.Q; r2 = bus.R;
                end
            end
        end
        check("b2b.done_count", done_edges.size(), 2);
        check("b2b.first_edge", (done_edges.size() > 0) ? done_edges[0] : -1, 10);
        check("b2b.second_edge", (done_edges.size() > 1) ? done_edges[1] : -1, 20);
        check("b2b.Q1", q1, 8'd11);
        check("b2b.R1", r1, 8'd1);
        check("b2b.Q2", q2, 8'd10);
        check("b2b.R2", r2, 8'd0);

        // Reset during an operation aborts it.
        // A start on the first edge after release is accepted.
        bus.start = 1'b1; bus.A = 8'd123; bus.B = 8'd7; bus.signed_mode = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst.Q", bus.Q, '0);
        check("midrst.R", bus.R, '0);
        check("midrst.busy", bus.busy, 1'b0);
        check("midrst.done", bus.done, 1'b0);
        check("midrst.state", dbg_state, 2'd0);
        dones_in_reset = 0;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (bus.done) dones_in_reset++;
        end
        check("midrst.no_done", dones_in_reset, 0);
        rst_n = 1'b1;
        mv = model(8'd123, 8'd3, 1'b0);
        op_and_check("after_rst", mv);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/divisor_nbit.md
DIVISOR_NBIT -- requirements
Module: divisor_nbit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting operand and result width; legal range 2..32.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have port start  input  1  request a division; sampled on rising edge of clk.
REQ-005 The module SHALL have port signed_mode  input  1  0 = unsigned operands, 1 = two's-complement; sampled with start.
REQ-006 The module SHALL have port A  input  WIDTH  dividend; sampled with start.
REQ-007 The module SHALL have port B  input  WIDTH  divisor; sampled with start.
REQ-008 The module SHALL have port Q  output  WIDTH  quotient.
REQ-009 The module SHALL have port R  output  WIDTH  remainder.
REQ-010 The module SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 The module SHALL have port busy  output  1  operation in progress, start ignored.
REQ-012 The module SHALL have port div_zero  output  1  last result came from B == 0.
REQ-013 The module SHALL have port ovf  output  1  last result was signed overflow (MIN / -1).

Function
REQ-014 The FSM SHALL have states IDLE, CALC, ADJ; done is a registered pulse raised on the transition back to IDLE.
REQ-015 start SHALL be accepted only on an edge where state is IDLE (busy = 0); start while busy SHALL be ignored with no effect on the operation or outputs.
REQ-016 On acceptance, A, B, signed_mode SHALL be latched; later input changes SHALL not affect the running operation.
REQ-017 Accepted start with B != 0 SHALL go IDLE -> CALC; CALC SHALL run exactly WIDTH cycles of restoring division, one quotient bit per cycle, MSB first, on operand magnitudes.
REQ-018 CALC SHALL go to ADJ for one cycle; ADJ SHALL apply sign correction, drive Q/R and go to IDLE, asserting done.
REQ-019 Latency: done SHALL be high in the cycle after the (WIDTH+2)-th rising edge counting the accepting edge as edge 1 (WIDTH=8: edge 10).
REQ-020 busy SHALL be high from the edge after acceptance until the edge that raises done; busy SHALL be 0 while done is 1.
REQ-021 A start present in the done cycle SHALL be accepted (back-to-back operation, no idle gap required).
REQ-022 Unsigned mode: Q = floor(A/B), R = A - Q*B, both WIDTH bits.
REQ-023 Signed mode: quotient SHALL truncate toward zero; R SHALL carry the sign of A (or be zero); |R| < |B|; A == Q*B + R.
REQ-024 B == 0 (either mode) SHALL take a fast path: IDLE stays IDLE, done SHALL pulse on the edge after acceptance, Q = all ones, R = A (raw bits), div_zero = 1, ovf = 0.
REQ-025 Signed mode with A = most-negative value and B = -1 SHALL give Q = most-negative value, R = 0, ovf = 1, div_zero = 0, normal latency.
REQ-026 Q, R, div_zero, ovf SHALL update only on the edge that raises done and SHALL hold until the next done.
REQ-027 The internal iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap during CALC.

Reset
REQ-028 While rst_n = 0, independent of clk: state = IDLE, Q = 0, R = 0, done = 0, busy = 0, div_zero = 0, ovf = 0, counter and internal registers = 0.
REQ-029 Reset asserted mid-operation SHALL abort it; no done SHALL follow; the first start after release SHALL behave as from power-up.
REQ-030 Deassertion SHALL take effect from the first rising edge of clk after rst_n rises; start on that edge SHALL be accepted.

Verification (WIDTH = 8)
REQ-031 Unsigned 0/5, 123/3, 255/7 -> Q=0 R=0; Q=41 R=0; Q=36 R=3; done exactly one cycle, on edge 10 each.
REQ-032 Signed -7/2 (0xF9/0x02) -> Q=0xFD (-3), R=0xFF (-1); signed 7/-2 -> Q=0xFD, R=0x01; flags 0.
REQ-033 B=0, A=0x5A -> done on edge 2, Q=0xFF, R=0x5A, div_zero=1; next normal division clears div_zero.
REQ-034 Signed -128/-1 (0x80/0xFF) -> Q=0x80, R=0x00, ovf=1.
REQ-035 start 100/9, then start 50/5 pulsed on edge 4 while busy -> only Q=11 R=1 produced; 50/5 issued in the done cycle -> Q=10 R=0 on edge 10 after.
REQ-036 rst_n low at edge 5 of a division -> all outputs 0 immediately, no done pulse; following 123/3 -> Q=41 R=0.
